// File: rtl/fpu_man_norm_iter.sv
// Back end of the FP add/sub datapath: normalizes the mantissa ALU result and packs an IEEE-754 single.
// Optional round-to-nearest-even on the carry-out path is enabled with `define FPU_NORM_ROUND_EN.
module fpu_man_norm_iter #(
  parameter int SIZE_MAN      = 24,
  parameter int SIZE_EXP      = 8,
  parameter int SHIFT_PER_CYC = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sign,
  input  logic [SIZE_EXP-1:0]          i_exp,
  input  logic [SIZE_MAN-1:0]          i_man_alu,
  input  logic                         i_overflow,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE_EXP+SIZE_MAN-1:0] o_result,
  output logic                         o_zero,
  output logic                         o_exp_ovf,
  output logic                         o_underflow
);

  localparam int LZW = $clog2(SIZE_MAN + 1);
  localparam logic [SIZE_EXP-1:0] EXP_MAX    = '1;
  localparam logic [SIZE_EXP-1:0] EXP_ONE    = SIZE_EXP'(1);
  localparam logic [SIZE_MAN-1:0] MAN_HIDDEN = {1'b1, {(SIZE_MAN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t              state, state_nxt;
  logic [SIZE_MAN-1:0] man_r, man_nxt;
  logic [SIZE_EXP-1:0] exp_r, exp_nxt;
  logic                sign_r, sign_nxt;
  logic                zero_r, zero_nxt;
  logic                ovf_r, ovf_nxt;
  logic                unf_r, unf_nxt;

  logic [SIZE_EXP:0]   exp_inc;
  logic [SIZE_MAN-1:0] man_ovf;
  logic [SIZE_EXP-1:0] lz_ext;
  logic [SIZE_EXP-1:0] exp_m1;
  logic [SIZE_EXP-1:0] shamt;
  logic [SIZE_EXP-1:0] exp_sh;
  logic [SIZE_MAN-1:0] man_sh;
`ifdef FPU_NORM_ROUND_EN
  logic [SIZE_MAN:0]   man_rnd;
`endif

  function automatic logic [LZW-1:0] count_lz(input logic [SIZE_MAN-1:0] v);
    count_lz = LZW'(SIZE_MAN);
    for (int i = 0; i < SIZE_MAN; i++) begin
      if (v[i]) count_lz = LZW'(SIZE_MAN - 1 - i);
    end
  endfunction

  // Carry-out path: shift right by one, bump exponent, optionally round on the dropped bit.
  always_comb begin
    exp_inc = {1'b0, i_exp} + (SIZE_EXP+1)'(1);
    man_ovf = {1'b1, i_man_alu[SIZE_MAN-1:1]};
`ifdef FPU_NORM_ROUND_EN
    man_rnd = {1'b0, man_ovf} + (SIZE_MAN+1)'(1);
    if (i_man_alu[0] && man_ovf[0]) begin
      if (man_rnd[SIZE_MAN]) begin
        man_ovf = MAN_HIDDEN;
        exp_inc = exp_inc + (SIZE_EXP+1)'(1);
      end else begin
        man_ovf = man_rnd[SIZE_MAN-1:0];
      end
    end
`endif
  end

  // One normalization step never shifts past exp==1, so denormals stop at the right scale.
  always_comb begin
    lz_ext = SIZE_EXP'(count_lz(man_r));
    exp_m1 = exp_r - EXP_ONE;
    shamt  = SIZE_EXP'(SHIFT_PER_CYC);
    if (lz_ext < shamt) shamt = lz_ext;
    if (exp_m1 < shamt) shamt = exp_m1;
    man_sh = man_r << shamt;
    exp_sh = exp_r - shamt;
  end

  assign o_ready = (state == IDLE) && !i_rst;

  always_comb begin
    state_nxt = state;
    man_nxt   = man_r;
    exp_nxt   = exp_r;
    sign_nxt  = sign_r;
    zero_nxt  = zero_r;
    ovf_nxt   = ovf_r;
    unf_nxt   = unf_r;
    case (state)
      IDLE: begin
        if (i_valid) begin
          sign_nxt  = i_sign;
          zero_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
          state_nxt = DONE;
          if (i_overflow) begin
            if (exp_inc >= {1'b0, EXP_MAX}) begin
              exp_nxt = EXP_MAX;
              man_nxt = MAN_HIDDEN;
              ovf_nxt = 1'b1;
            end else begin
              exp_nxt = exp_inc[SIZE_EXP-1:0];
              man_nxt = man_ovf;
            end
          end else if (i_man_alu == '0) begin
            exp_nxt  = '0;
            man_nxt  = '0;
            zero_nxt = 1'b1;
          end else if (i_exp == '0) begin
            man_nxt = i_man_alu;
            if (i_man_alu[SIZE_MAN-1]) begin
              exp_nxt = EXP_ONE;
            end else begin
              exp_nxt = '0;
              unf_nxt = 1'b1;
            end
          end else begin
            man_nxt = i_man_alu;
            exp_nxt = i_exp;
            if (!i_man_alu[SIZE_MAN-1]) begin
              if (i_exp > EXP_ONE) begin
                state_nxt = NORM;
              end else begin
                exp_nxt = '0;
                unf_nxt = 1'b1;
              end
            end
          end
        end
      end
      NORM: begin
        man_nxt = man_sh;
        exp_nxt = exp_sh;
        if (man_sh[SIZE_MAN-1]) begin
          state_nxt = DONE;
        end else if (exp_sh == EXP_ONE) begin
          exp_nxt   = '0;
          unf_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      man_r  <= '0;
      exp_r  <= '0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      man_r  <= man_nxt;
      exp_r  <= exp_nxt;
      sign_r <= sign_nxt;
      zero_r <= zero_nxt;
      ovf_r  <= ovf_nxt;
      unf_r  <= unf_nxt;
    end
  end

  assign o_valid     = (state == DONE);
  assign o_result    = {sign_r, exp_r, man_r[SIZE_MAN-2:0]};
  assign o_zero      = zero_r;
  assign o_exp_ovf   = ovf_r;
  assign o_underflow = unf_r;

endmodule

// File: tb/tb_fpu_man_norm_iter.sv
// Directed table-driven bench for fpu_man_norm_iter, plus hold, busy and reset-in-flight sequences.
module tb_fpu_man_norm_iter;

  localparam int SPC = 1;

  typedef struct {
    string       name;
    logic        sgn;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        ovf;
    logic [31:0] res;
    logic [2:0]  flags;
    int          shifts;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_sign = 1'b0;
  logic [7:0]  i_exp = '0;
  logic [23:0] i_man_alu = '0;
  logic        i_overflow = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready, o_valid, o_zero, o_exp_ovf, o_underflow;
  logic [31:0] o_result;

  int tests = 0;
  int failures = 0;
  vec_t vecs[$];

  fpu_man_norm_iter #(.SIZE_MAN(24), .SIZE_EXP(8), .SHIFT_PER_CYC(SPC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man_alu(i_man_alu), .i_overflow(i_overflow),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_zero(o_zero), .o_exp_ovf(o_exp_ovf), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic addVec(input string name, input logic sgn, input logic [7:0] exp,
                        input logic [23:0] man, input logic ovf, input logic [31:0] res,
                        input logic [2:0] flags, input int shifts);
    vec_t v;
    v.name = name; v.sgn = sgn; v.exp = exp; v.man = man; v.ovf = ovf;
    v.res = res; v.flags = flags; v.shifts = shifts;
    vecs.push_back(v);
  endtask

  // Present one transaction, wait for the accept edge, then count cycles until o_valid.
  task automatic applyStimulus(input vec_t v, output int lat);
    int n;
    @(negedge i_clk);
    i_sign = v.sgn; i_exp = v.exp; i_man_alu = v.man; i_overflow = v.ovf;
    i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    checkOutput({v.name, " busy"}, {31'd0, o_ready}, 32'd0);
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult(input string name);
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    checkOutput({name, " valid_drop"}, {31'd0, o_valid}, 32'd0);
    checkOutput({name, " ready_back"}, {31'd0, o_ready}, 32'd1);
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    applyStimulus(v, lat);
    checkOutput({v.name, " result"}, o_result, v.res);
    checkOutput({v.name, " flags"}, {29'd0, o_zero, o_exp_ovf, o_underflow}, {29'd0, v.flags});
    checkOutput({v.name, " latency"}, lat, 1 + (v.shifts + SPC - 1) / SPC);
    releaseResult(v.name);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t hv;
    int lat;

    // flags are {zero, exp_ovf, underflow}
    addVec("plain",        1'b0, 8'h80, 24'hC00000, 1'b0, 32'h40400000, 3'b000, 0);
    addVec("norm23",       1'b0, 8'h80, 24'h000001, 1'b0, 32'h34800000, 3'b000, 23);
    addVec("inf",          1'b0, 8'hFE, 24'h123456, 1'b1, 32'h7F800000, 3'b010, 0);
    addVec("zero_neg",     1'b1, 8'h45, 24'h000000, 1'b0, 32'h80000000, 3'b100, 0);
    addVec("unf_stop",     1'b0, 8'h03, 24'h000100, 1'b0, 32'h00000400, 3'b001, 2);
    addVec("denorm",       1'b0, 8'h00, 24'h000ABC, 1'b0, 32'h00000ABC, 3'b001, 0);
    addVec("denorm_hid",   1'b1, 8'h00, 24'h812345, 1'b0, 32'h80812345, 3'b000, 0);
    addVec("carry",        1'b1, 8'h10, 24'h900002, 1'b1, 32'h88C80001, 3'b000, 0);
    addVec("carry_even",   1'b0, 8'h30, 24'h000001, 1'b1, 32'h18800000, 3'b000, 0);
    addVec("norm3",        1'b0, 8'h05, 24'h100000, 1'b0, 32'h01000000, 3'b000, 3);
    addVec("exp1_unf",     1'b0, 8'h01, 24'h400000, 1'b0, 32'h00400000, 3'b001, 0);
    addVec("exp2_unf",     1'b0, 8'h02, 24'h000001, 1'b0, 32'h00000002, 3'b001, 1);
`ifdef FPU_NORM_ROUND_EN
    addVec("round_carry",  1'b0, 8'h7F, 24'hFFFFFF, 1'b1, 32'h40800000, 3'b000, 0);
    addVec("round_up",     1'b0, 8'h20, 24'h000003, 1'b1, 32'h10800002, 3'b000, 0);
    addVec("round_inf",    1'b0, 8'hFD, 24'hFFFFFF, 1'b1, 32'h7F800000, 3'b010, 0);
`else
    addVec("round_carry",  1'b0, 8'h7F, 24'hFFFFFF, 1'b1, 32'h407FFFFF, 3'b000, 0);
    addVec("round_up",     1'b0, 8'h20, 24'h000003, 1'b1, 32'h10800001, 3'b000, 0);
    addVec("round_inf",    1'b0, 8'hFD, 24'hFFFFFF, 1'b1, 32'h7F7FFFFF, 3'b000, 0);
`endif

    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset ready", {31'd0, o_ready}, 32'd0);
    checkOutput("reset valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset result", o_result, 32'd0);
    checkOutput("reset flags", {29'd0, o_zero, o_exp_ovf, o_underflow}, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("post_reset ready", {31'd0, o_ready}, 32'd1);

    foreach (vecs[i]) runVector(vecs[i]);

    // Held result while downstream stalls; i_valid with other data must be ignored.
    hv = vecs[0];
    applyStimulus(hv, lat);
    checkOutput("hold latency", lat, 1);
    i_valid = 1'b1; i_man_alu = 24'h000000; i_sign = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk);
      #1;
      checkOutput($sformatf("hold%0d result", k), o_result, 32'h40400000);
      checkOutput($sformatf("hold%0d ready", k), {31'd0, o_ready}, 32'd0);
      checkOutput($sformatf("hold%0d valid", k), {31'd0, o_valid}, 32'd1);
    end
    i_valid = 1'b0;
    releaseResult("hold");

    // Reset while normalizing discards the transaction.
    @(negedge i_clk);
    i_sign = 1'b1; i_exp = 8'h80; i_man_alu = 24'h000001; i_overflow = 1'b0;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("midnorm valid", {31'd0, o_valid}, 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("rst_norm valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_norm result", o_result, 32'd0);
    checkOutput("rst_norm flags", {29'd0, o_zero, o_exp_ovf, o_underflow}, 32'd0);
    checkOutput("rst_norm ready", {31'd0, o_ready}, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("rst_norm ready_after", {31'd0, o_ready}, 32'd1);
    checkOutput("rst_norm valid_after", {31'd0, o_valid}, 32'd0);

    // A fresh transaction after the aborted one completes normally.
    runVector(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
